// File: rtl/freq_ctr_pkg.sv
// Shared types and constants for the frequency-counter BCD datapath.
// Imported by bcd_decade and freq_bcd_accum.
package freq_ctr_pkg;

  localparam int NUM_DIGITS_DEF = 8;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX    = 4'd9;
  localparam bcd_digit_t BLANK_CODE = 4'hF;

  // Decimal successor of one decade: 9 rolls back to 0.
  function automatic bcd_digit_t bcd_inc(input bcd_digit_t d);
    return (d == BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/freq_bcd_accum_decade.sv
// One BCD decade of the running count: steps on en_in, clears on clr,
// and passes the enable onward when it is about to roll over.
module bcd_decade
  import freq_ctr_pkg::*;
(
  input  logic       fpga_clk,
  input  logic       nreset,
  input  logic       en_in,
  input  logic       clr,
  output logic [3:0] digit,
  output logic       en_out
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;

  // Clear wins over a same-cycle enable, so a pulse arriving with reset_ctr is dropped.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (en_in) begin
      digit_d = bcd_inc(digit_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge fpga_clk or negedge nreset) begin
    if (!nreset) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit  = digit_q;
  assign en_out = en_in && (digit_q == BCD_MAX);

endmodule

// File: rtl/freq_bcd_accum.sv
// 8-decade BCD event accumulator with gate-end capture, leading-zero blanking
// and digit readout. Define BCD_SATURATE_EN to hold at 99999999 instead of wrapping.
module freq_bcd_accum
  import freq_ctr_pkg::*;
#(
  parameter int         NUM_DIGITS = NUM_DIGITS_DEF,
  parameter logic [3:0] BLANK_CODE = freq_ctr_pkg::BLANK_CODE,
  localparam int        SEL_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic             fpga_clk,
  input  logic             nreset,
  input  logic             clk_enable,
  input  logic             latchit,
  input  logic             reset_ctr,
  input  logic [SEL_W-1:0] digit_select,
  output logic [3:0]       digit_muxed,
  output logic             carry_out
);

  localparam logic [NUM_DIGITS-1:0] BLANK_RST = ~NUM_DIGITS'(1);

  logic [NUM_DIGITS-1:0][3:0] run_digits;
  logic [NUM_DIGITS:0]        en_chain;
  logic                       inc_en;
  logic                       carry_d;
  logic                       carry_q;

  logic [NUM_DIGITS-1:0][3:0] latch_q;
  logic [NUM_DIGITS-1:0]      blank_q;
  logic [NUM_DIGITS-1:0]      blank_d;

  assign en_chain[0] = inc_en;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dec
    bcd_decade u_dec (
      .fpga_clk (fpga_clk),
      .nreset   (nreset),
      .en_in    (en_chain[k]),
      .clr      (reset_ctr),
      .digit    (run_digits[k]),
      .en_out   (en_chain[k+1])
    );
  end

`ifdef BCD_SATURATE_EN
  logic all_nine;
  logic ovf_q;
  logic ovf_d;

  always_comb begin
    all_nine = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      all_nine = all_nine && (run_digits[k] == BCD_MAX);
    end
  end

  // Increments stop at full scale; the first refused pulse flags over-range once.
  assign inc_en = clk_enable && !all_nine;

  always_comb begin
    ovf_d   = ovf_q;
    carry_d = 1'b0;
    if (reset_ctr) begin
      ovf_d = 1'b0;
    end else if (clk_enable && all_nine && !ovf_q) begin
      ovf_d   = 1'b1;
      carry_d = 1'b1;
    end
  end

  always_ff @(posedge fpga_clk or negedge nreset) begin
    if (!nreset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
`else
  assign inc_en  = clk_enable;
  // Enable rippling out of the top decade means 99999999 just rolled to zero.
  assign carry_d = en_chain[NUM_DIGITS] && !reset_ctr;
`endif

  // Digit k (k >= 1) is a leading zero when it and every higher decade are zero.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank_d    = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above && (run_digits[k] == 4'd0);
      blank_d[k] = zero_above;
    end
  end

  // NOTE: the display latch is a small register array, not a RAM, so it is reset with the rest of the state.
  always_ff @(posedge fpga_clk or negedge nreset) begin
    if (!nreset) begin
      latch_q <= '0;
      blank_q <= BLANK_RST;
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
      if (latchit) begin
        latch_q <= run_digits;
        blank_q <= blank_d;
      end
    end
  end

  assign carry_out = carry_q;

  always_comb begin
    digit_muxed = BLANK_CODE;
    if (int'({1'b0, digit_select}) < NUM_DIGITS && !blank_q[digit_select]) begin
      digit_muxed = latch_q[digit_select];
    end
  end

endmodule
